// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param
// Description : Parametrised single-clock FIFO with occupancy, almost flags,
//               sticky error flags and registered or show-ahead read port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int AFULL_LEVEL  = 28,
    parameter int AEMPTY_LEVEL = 4,
    parameter int SHOW_AHEAD   = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  dataout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH      = 2 ** ADDR_WIDTH;
    localparam int                PTR_W      = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0]  AFULL_CNT  = PTR_W'(AFULL_LEVEL);
    localparam logic [PTR_W-1:0]  AEMPTY_CNT = PTR_W'(AEMPTY_LEVEL);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

    if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > DEPTH)) begin : g_bad_afull
        $error("fifo_sync_param: AFULL_LEVEL=%0d outside 1..%0d", AFULL_LEVEL, DEPTH);
    end
    if ((AEMPTY_LEVEL < 0) || (AEMPTY_LEVEL > DEPTH - 1)) begin : g_bad_aempty
        $error("fifo_sync_param: AEMPTY_LEVEL=%0d outside 0..%0d", AEMPTY_LEVEL, DEPTH - 1);
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    // The extra pointer MSB distinguishes a full ring from an empty one.
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) && (wr_addr == rd_addr);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AFULL_CNT);
    assign almost_empty = (count <= AEMPTY_CNT);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign rd_en = read & ~empty;
    assign wr_en = write & (~full | rd_en);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q | (write & ~wr_en);
        underflow_d = underflow_q | (read & ~rd_en);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (reset_n && wr_en) begin
            mem[wr_addr] <= datain;
        end
    end

    if (SHOW_AHEAD == 0) begin : g_registered_read
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  dvalid_q, dvalid_d;

        always_comb begin
            dout_d   = dout_q;
            dvalid_d = rd_en;
            if (rd_en) begin
                dout_d = mem[rd_addr];
            end
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                dout_q   <= '0;
                dvalid_q <= 1'b0;
            end else begin
                dout_q   <= dout_d;
                dvalid_q <= dvalid_d;
            end
        end

        assign dataout       = dout_q;
        assign dataout_valid = dvalid_q;
    end else begin : g_show_ahead
        assign dataout       = mem[rd_addr];
        assign dataout_valid = ~empty;
    end

endmodule
`default_nettype wire
